ibus_mem_resp: RTL
==================

IBUS_MEM_RESP -- requirements
Module: ibus_mem_resp

Interface
REQ-001 The block SHALL have parameter p_base_addr, default 32'hf0000000, byte address of memory word 0.
REQ-002 The block SHALL have parameter p_depth, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-003 The block SHALL have parameter p_wait_states, default 0, extra cycles before ack (0..7).
REQ-004 The block SHALL have port i_clk  input  1  global clock; one clock domain only.
REQ-005 The block SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port ibus_addr  input  32  request byte address.
REQ-007 The block SHALL have port ibus_be  input  4  write byte enables.
REQ-008 The block SHALL have port ibus_wr_en  input  1  write request.
REQ-009 The block SHALL have port ibus_wr_data  input  32  write data.
REQ-010 The block SHALL have port ibus_rd_en  input  1  read request.
REQ-011 The block SHALL have port ibus_rd_data  output  32  read data.
REQ-012 The block SHALL have port ibus_busy  output  1  request in progress, new requests ignored.
REQ-013 The block SHALL have port ibus_ack  output  1  one-cycle transfer-complete pulse.
REQ-014 The block SHALL have port o_err  output  1  one-cycle pulse with ack when the address was out of range.

Function
REQ-015 Storage SHALL be p_depth x 32 bits, word index = (ibus_addr - p_base_addr) >> 2; ibus_addr[1:0] ignored.
REQ-016 Out of range SHALL mean (ibus_addr - p_base_addr) >= 4*p_depth, unsigned 32-bit compare, wrap-around below base counts as out of range.
REQ-017 FSM states SHALL be IDLE, WAIT, ACK.
REQ-018 A request SHALL be accepted on a rising edge when state is IDLE or ACK and (ibus_rd_en or ibus_wr_en); address, be, data, type are registered at acceptance.
REQ-019 On acceptance: p_wait_states=0 -> next state ACK; else -> WAIT with counter loaded to p_wait_states-1.
REQ-020 WAIT SHALL decrement the counter each cycle and go to ACK when counter is 0, giving ack exactly p_wait_states+1 cycles after acceptance.
REQ-021 ACK SHALL go to IDLE when no request is present, or directly re-accept a present request (back-to-back, one transfer per cycle when p_wait_states=0).
REQ-022 ibus_busy SHALL be 1 exactly in WAIT; requests presented during WAIT SHALL be ignored, not queued.
REQ-023 ibus_ack SHALL be 1 exactly in ACK.
REQ-024 Read: ibus_rd_data SHALL present the addressed word during the ACK cycle and hold it until the next read ack; out-of-range reads return 32'h00000000.
REQ-025 Write: in ACK cycle, each byte lane i with be[i]=1 SHALL be written; be=4'b0000 writes nothing but is still acked; ibus_rd_data is unchanged by writes.
REQ-026 Out-of-range writes SHALL modify no storage.
REQ-027 If ibus_rd_en and ibus_wr_en are both 1 at acceptance, the write SHALL be performed and the read discarded (single ack).
REQ-028 o_err SHALL be 1 in the ACK cycle of an out-of-range transfer, else 0.
REQ-029 A write followed back-to-back by a read of the same word SHALL return the newly written data.

Reset
REQ-030 Assertion of i_rst_n=0 SHALL immediately force state IDLE, wait counter 0, ibus_busy=0, ibus_ack=0, o_err=0, ibus_rd_data=32'h0, independent of i_clk.
REQ-031 Reset mid-transfer SHALL abort it: no ack, no storage write; storage contents are not reset.
REQ-032 First request SHALL be accepted on the first rising edge with i_rst_n=1.

Verification
REQ-033 p_wait_states=0, rd_en held 1, addresses 0xf0000000,+4,+8 every cycle -> ack every cycle, rd_data = words 0,1,2 one cycle after each address.
REQ-034 p_wait_states=3, read 0xf0000010 -> busy 1 for 3 cycles, ack on 4th cycle after acceptance with word 4; request changed during busy ignored.
REQ-035 Write 0xf0000020 data 0xAABBCCDD be=4'b0101 over prior 0x11223344, then read -> 0x11BB33DD.
REQ-036 Read 0x00000000 and 0xf0001000 (p_depth=1024) -> ack with o_err=1, rd_data 0; write there -> o_err=1, storage unchanged.
REQ-037 rd_en and wr_en both 1 at 0xf0000004 data 0xDEADBEEF be=4'b1111 -> one ack, subsequent read returns 0xDEADBEEF.
REQ-038 i_rst_n pulsed low asynchronously during WAIT of a write -> busy/ack/o_err drop immediately, no ack issued, target word unchanged.

Source files
------------

// File: rtl/ibus_mem_resp.sv
`default_nettype none
// ibus_mem_resp: word-organised memory slave on the ibus with configurable wait
// states, byte-lane writes and an out-of-range error pulse alongside ack.
module ibus_mem_resp #(
  parameter logic [31:0] p_base_addr   = 32'hf000_0000,
  parameter int          p_depth       = 1024,
  parameter int          p_wait_states = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] ibus_addr,
  input  logic [3:0]  ibus_be,
  input  logic        ibus_wr_en,
  input  logic [31:0] ibus_wr_data,
  input  logic        ibus_rd_en,
  output logic [31:0] ibus_rd_data,
  output logic        ibus_busy,
  output logic        ibus_ack,
  output logic        o_err
);

  localparam int          AW        = $clog2(p_depth);
  localparam logic [31:0] SPAN      = 32'(4 * p_depth);
  localparam int          WS_M1     = (p_wait_states > 0) ? p_wait_states - 1 : 0;
  localparam logic [2:0]  WAIT_LOAD = 3'(WS_M1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx_in;
  logic        accept;

  logic [AW-1:0] idx_q;
  logic          err_q;
  logic          wr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic          load_rd;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   rd_word;

  logic [31:0] mem [p_depth];

  // Unsigned subtract makes addresses below the base wrap to huge offsets.
  assign offset   = ibus_addr - p_base_addr;
  assign in_range = offset < SPAN;
  assign idx_in   = offset[AW+1:2];
  assign accept   = (state == IDLE || state == ACK) && (ibus_rd_en || ibus_wr_en);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE, ACK: begin
        if (accept) begin
          state_d = (p_wait_states == 0) ? ACK : WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_d = ACK;
        else             cnt_d   = cnt - 3'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Read data is captured on the edge that enters ACK; with zero wait states
  // that is the acceptance edge, so a write completing on the same edge is
  // forwarded into the captured word.
  always_comb begin
    rd_idx  = (state == WAIT) ? idx_q : idx_in;
    rd_err  = (state == WAIT) ? err_q : !in_range;
    load_rd = (state == WAIT && cnt == 3'd0 && !wr_q) ||
              (accept && p_wait_states == 0 && !ibus_wr_en);
    rd_word = mem[rd_idx];
    if (state == ACK && wr_q && !err_q && idx_q == rd_idx) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      ibus_rd_data <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        idx_q   <= idx_in;
        err_q   <= !in_range;
        wr_q    <= ibus_wr_en;
        be_q    <= ibus_be;
        wdata_q <= ibus_wr_data;
      end
      if (load_rd) ibus_rd_data <= rd_err ? 32'd0 : rd_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == ACK && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ibus_busy = (state == WAIT);
  assign ibus_ack  = (state == ACK);
  assign o_err     = (state == ACK) && err_q;

endmodule
`default_nettype wire
